// File: rtl/wb_resp_pkg.sv
// Shared constants for the Wishbone register responder: register map,
// CTRL/STATUS bit positions and the bus-handshake state encoding.
package wb_resp_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CMD    = 2'd3;

  localparam int CTRL_EN = 7;
  localparam int CTRL_IE = 6;

  localparam int STAT_IRQ   = 7;
  localparam int STAT_OVF   = 6;
  localparam int STAT_UDF   = 5;
  localparam int STAT_FULL  = 4;
  localparam int STAT_EMPTY = 3;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_e;

  function automatic logic [7:0] pack_status(input logic irq_pend, input logic ovf,
                                             input logic udf, input logic full,
                                             input logic empty, input logic [2:0] count);
    return {irq_pend, ovf, udf, full, empty, count};
  endfunction

endpackage

// File: rtl/wb_resp_fifo.sv
// Small synchronous FIFO for the DATA loopback register; the head entry is
// always visible on o_data so a pop can capture it on the same edge.
module wb_resp_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full & ~i_flush;
  assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_resp_regs.sv
// Wishbone classic-cycle slave with four byte registers, programmable wait
// states before ack, a loopback data FIFO and a gated level interrupt.
module wb_resp_regs
  import wb_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  bus_state_e            r_state;
  logic [2:0]            r_wait_cnt;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_cmd;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_irq_pend;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_irq;

  logic                  w_req;
  logic                  w_enter_ack;
  logic                  w_wr;
  logic                  w_rd;
  logic [1:0]            w_sel;
  logic                  w_en;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [2:0]            w_count3;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic                  w_full_set;
  logic                  w_cmd_set;
  logic                  w_stat_clr;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_req = cyc_i & stb_i;

  // The edge entering ACK is the single point where the access takes effect.
  assign w_enter_ack = ((r_state == BUS_IDLE) && w_req && (WAIT_STATES == 0)) ||
                       ((r_state == BUS_WAIT) && w_req && (r_wait_cnt == 3'd0));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= BUS_IDLE;
      r_wait_cnt <= 3'd0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        BUS_IDLE: begin
          if (w_req) begin
            if (WAIT_STATES == 0) begin
              r_state <= BUS_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state    <= BUS_WAIT;
              r_wait_cnt <= 3'(WAIT_STATES - 1);
            end
          end
        end
        BUS_WAIT: begin
          if (!w_req) begin
            r_state <= BUS_IDLE;
          end else if (r_wait_cnt == 3'd0) begin
            r_state <= BUS_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        BUS_ACK: r_state <= BUS_IDLE;
        default: r_state <= BUS_IDLE;
      endcase
    end
  end

  assign w_wr  = w_enter_ack & we_i;
  assign w_rd  = w_enter_ack & ~we_i;
  assign w_sel = adr_i[1:0];
  assign w_en  = r_ctrl[CTRL_EN];

  wb_resp_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_flush (~w_en),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (dat_i),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_push     = w_wr & (w_sel == ADDR_DATA) & w_en & ~w_fifo_full;
  assign w_ovf_set  = w_wr & (w_sel == ADDR_DATA) & w_en & w_fifo_full;
  assign w_pop      = w_rd & (w_sel == ADDR_DATA) & ~w_fifo_empty;
  assign w_udf_set  = w_rd & (w_sel == ADDR_DATA) & w_fifo_empty;
  assign w_full_set = w_push & (w_fifo_count == CNT_W'(FIFO_DEPTH - 1));
  assign w_cmd_set  = w_wr & (w_sel == ADDR_CMD) & dat_i[0];
  assign w_stat_clr = w_rd & (w_sel == ADDR_STATUS);
  assign w_count3   = 3'(w_fifo_count);
  assign w_status   = pack_status(r_irq_pend, r_ovf, r_udf, w_fifo_full, w_fifo_empty, w_count3);

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      ADDR_CTRL:   w_rd_data = r_ctrl;
      ADDR_DATA:   w_rd_data = w_fifo_empty ? '0 : w_fifo_head;
      ADDR_STATUS: w_rd_data = w_status;
      ADDR_CMD:    w_rd_data = r_cmd;
      default:     w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl     <= '0;
      r_cmd      <= '0;
      r_dat      <= '0;
      r_irq_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_sel == ADDR_CTRL)) r_ctrl <= dat_i;
      if (w_wr && (w_sel == ADDR_CMD))  r_cmd  <= dat_i;
      if (w_rd)                         r_dat  <= w_rd_data;
      // Set events take priority over the STATUS clear-on-read.
      r_irq_pend <= (r_irq_pend & ~w_stat_clr) | w_cmd_set | w_full_set;
      r_ovf      <= (r_ovf & ~w_stat_clr) | w_ovf_set;
      r_udf      <= (r_udf & ~w_stat_clr) | w_udf_set;
      r_irq      <= r_irq_pend & r_ctrl[CTRL_IE] & r_ctrl[CTRL_EN];
    end
  end

  assign ack_o = r_ack;
  assign dat_o = r_dat;
  assign irq_o = r_irq;

endmodule

// File: doc/wb_resp_regs.md
# wb_resp_regs

Synthesizable Wishbone classic-cycle responder: the slave end of the bus our Wishbone master BFM drives. It exposes four byte-wide registers (control, data FIFO, status, command), inserts a programmable number of wait states before `ack_o`, and raises a level interrupt gated by the control-register interrupt-enable bit. It is the DUT-side target for the Wishbone master driver and monitor, and serves as a reusable register front end.

## Interface
- `ADDR_WIDTH`, 2: register address width; only 4 registers are decoded.
- `DATA_WIDTH`, 8: bus data width; fixed at 8.
- `WAIT_STATES`, 1: cycles inserted between the `stb_i` sample and `ack_o`; legal values are 0..7.
- `FIFO_DEPTH`, 4: data FIFO depth; legal values are 2 or 4.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `cyc_i` in 1: bus cycle.
- `stb_i` in 1: strobe.
- `we_i` in 1: 1 = write.
- `adr_i` in ADDR_WIDTH: register address.
- `dat_i` in DATA_WIDTH: write data.
- `ack_o` out 1: one-cycle acknowledge; reset value 0.
- `dat_o` out DATA_WIDTH: read data, valid while `ack_o` = 1; reset value 0.
- `irq_o` out 1: level interrupt; reset value 0.

## Operation
**Register map**
- 0 CTRL (RW, reset 0x00): bit7 = EN, bit6 = IE; other bits are stored and read back.
- 1 DATA:
  - Write pushes to the FIFO.
  - Read pops the FIFO (loopback).
- 2 STATUS (RO): bit7 = irq_pend, bit6 = ovf, bit5 = udf, bit4 = full, bit3 = empty, bits 2:0 = count.
- 3 CMD (RW, reset 0x00): a write with bit0 = 1 sets irq_pend; reads return the last value written.

**Bus FSM states:** IDLE, WAIT, ACK.
- IDLE to WAIT: `cyc_i & stb_i` sampled high and `WAIT_STATES` > 0. Load a down-counter with `WAIT_STATES`-1.
- IDLE to ACK: the same condition with `WAIT_STATES` = 0.
- WAIT: decrement the counter; move to ACK when it reaches 0.
- WAIT abort: if `cyc_i` or `stb_i` is low in WAIT, return to IDLE with no ack and no side effect.
- ACK to IDLE: unconditional. The master drops `stb_i` one edge after seeing ack, so IDLE ignores that stale cycle.
- Address, `we_i` and `dat_i` are sampled at the edge that enters ACK.
- Register write, FIFO push/pop, `dat_o` load and STATUS clear-on-read all occur at that same edge.

**FIFO rules**
- EN = 0: the FIFO is held empty and DATA writes are dropped without setting ovf.
- Push when full: data is dropped and ovf is set.
- Pop when empty: returns 0x00 and sets udf.
- Pointers wrap modulo `FIFO_DEPTH`.
- count ranges 0..`FIFO_DEPTH`.

**Interrupt**
- irq_pend is set by a CMD write with bit0 = 1, or by the FIFO count transitioning to full.
- A STATUS read returns the pre-clear value, then clears irq_pend, ovf and udf.
- If a set event coincides with a STATUS read, the set wins.
- `irq_o` = irq_pend & IE & EN, registered.
- Writes to the read-only STATUS register are acked and ignored.

## Timing
- With `cyc_i`/`stb_i` first sampled high at edge n, `ack_o` is high from edge n+`WAIT_STATES` to edge n+`WAIT_STATES`+1, exactly one cycle.
- `dat_o` is valid during the ack cycle and holds its value afterward.
- `irq_o` follows its cause by one edge after the ack edge.
- Back-to-back transfers: at most one ack every `WAIT_STATES`+2 cycles.
- Reset asserted mid-transfer: FSM goes to IDLE, the FIFO empties, all registers clear, and `ack_o`, `dat_o` and `irq_o` go to 0 immediately.

## Structure
- `wb_resp_pkg`: register address constants, CTRL/STATUS bit indices, and the FSM state enum (IDLE/WAIT/ACK).
- Sub-module `wb_resp_fifo`:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Async active-low reset and a synchronous flush input.
  - Parameterized by `FIFO_DEPTH` and `DATA_WIDTH`.

## Test plan
- **CTRL readback:** write CTRL = 0xC5, then read addr 0. Expect 0xC5, with ack exactly 1 cycle wide, asserted `WAIT_STATES` edges after `stb_i` is sampled.
- **FIFO fill and drain:**
  - Set EN = 1, then write 0x11, 0x22, 0x33, 0x44 to DATA.
  - Read STATUS: expect 0x94 (irq_pend, full, count = 4).
  - Read DATA four times: expect 0x11 → 0x44 in order.
  - Read STATUS again: expect 0x08.
- **Overflow and underflow:**
  - Write a fifth value while full, then read STATUS: expect ovf = 1.
  - Drain the FIFO, read DATA while empty: expect 0x00, then STATUS shows udf = 1.
  - Read STATUS again: ovf and udf read 0.
- **Interrupt gating:**
  - CTRL = 0x80, CMD = 0x01: `irq_o` stays 0.
  - CTRL = 0xC0: `irq_o` goes to 1 one edge after the ack.
  - STATUS read: `irq_o` returns to 0.
- **Abort:** drop `stb_i` during WAIT with `WAIT_STATES` = 3. Expect no ack, and FIFO count and registers unchanged.
- **Reset mid-transfer:** assert `rst_i` = 0 during WAIT. `ack_o`, `dat_o` and `irq_o` go to 0 asynchronously, and CTRL reads 0x00 after release.
